decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised N-wide registered RV32 decode stage sitting between the fetch bundle register and issue. It decodes up to N_INSTR_PER_CYCLE instructions per cycle into fields, sign-extended immediates and 8-bit control words. Results are held in one output register stage with a valid/ready handshake, so issue can back-pressure fetch. Flush support lets a redirect squash in-flight bundles, and optional intra-bundle RAW dependency flags let issue split a bundle.

## Interface
- INSTR_WIDTH, 32, instruction width in bits; only 32 is supported.
- N_INSTR_PER_CYCLE, 2, number of decode lanes, legal range 1..4; lane 0 is the oldest instruction.
- clk  input  1  clock, rising edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch bundle present.
- in_ready  output  1  stage can accept a bundle this cycle.
- in_lane_mask  input  N  per-lane valid within the bundle.
- instr_in  input  N*INSTR_WIDTH  lane i at bits [i*32 +: 32].
- flush  input  1  squash held and incoming bundle.
- out_valid  output  1  decoded bundle held.
- out_ready  input  1  issue consumes the bundle.
- lane_valid  output  N  registered in_lane_mask.
- opcode, rd, funct3, rs1, rs2, funct7  output  N*7, N*5, N*3, N*5, N*5, N*7  per-lane fields, packed the same way as instr_in.
- imm  output  N*32  per-lane immediate.
- ctrls  output  N*8  per-lane control word:
  - [7] REGWRITE
  - [6] ALUSRC
  - [5] MEMTOREG
  - [4] MEMRE
  - [3] MEMWR
  - [2] BYTEORWORD
  - [1:0] ALUOP
- dep_raw  output  N  lane i reads a register written by an older valid lane of the same bundle.

## Operation
- **Per-lane decode** (combinational, before the register), selected by opcode:
  - **R-type (0110011):** all fields from instr; imm = 0; ctrls = 0x82.
  - **Load (0000011):** rd, funct3, rs1 from instr; rs2 = funct7 = 0; imm = sext(instr[31:20]); ctrls = 1111_0b_00, with b = 0 when funct3 == 000, else 1.
  - **I-type (0010011):** as load; ctrls = 0xC6.
  - **Store (0100011):** rd = 0; funct3, rs1, rs2 from instr; funct7 = 0; imm = sext({instr[31:25], instr[11:7]}); ctrls = 0100_1b_10, with b as for load.
  - **LUI (0110111):** rd and funct3 from instr; rs1 = rs2 = funct7 = 0; imm = {instr[31:12], 12'b0}; ctrls = 0xC4.
  - **Any other opcode:** all fields, imm and ctrls = 0.
  - **Masked lane** (in_lane_mask[i] = 0): opcode and all fields forced to 0.
- **Dependency flags:** dep_raw[i] = 1 when some older lane j < i has lane_valid[j] = 1, REGWRITE = 1, rd[j] != 0, and rd[j] equals rs1[i] or rs2[i] of valid lane i. dep_raw[0] is always 0.
- **Handshake:**
  - in_ready = !out_valid | out_ready.
  - A transfer into the stage occurs when in_valid & in_ready & !flush.
  - On a transfer, all outputs load and out_valid becomes 1.
  - If out_ready = 1 with no new transfer, out_valid clears; output fields hold their last value.
- **Flush:**
  - flush = 1 clears out_valid on the next edge, regardless of in_valid and out_ready.
  - The incoming bundle is dropped; in_ready may still read 1, but no transfer occurs.
  - Flush has priority over every other event.
- **Stall:** while out_valid = 1 and out_ready = 0, every output is held bit-stable and in_ready = 0.

## Timing
- **Reset:** while rst = 1, out_valid = 0, lane_valid = 0, dep_raw = 0, and every field, imm and ctrls = 0. in_ready = 1 after reset.
- **Latency:** one cycle. A bundle accepted at edge k is visible on the outputs after edge k.
- **Throughput:** one bundle per cycle while out_ready = 1. Simultaneous consume and accept is a back-to-back transfer with no bubble.
- **Reset mid-bundle:** asserting rst asynchronously discards the held bundle; no partial-lane state survives.
- in_ready depends combinationally on out_ready only; there is no combinational path from instr_in to any output.

## Configuration
- **DECODE_HAZARD_EN defined:** the dep_raw comparators are built and dep_raw is registered with the bundle.
- **DECODE_HAZARD_EN undefined:** dep_raw is tied to 0 and no comparators are built. All other behaviour is identical.

## Test plan
- **Reset:** assert rst mid-stream -> out_valid = 0, ctrls = 0, imm = 0 immediately; in_ready = 1 after release.
- **R-type + load:** lane0 0x002081B3 (ADD x3,x1,x2), lane1 0xFFC0A283 (LW x5,-4(x1)), mask 11 -> next cycle:
  - lane0: rd = 3, rs1 = 1, rs2 = 2, ctrls = 0x82.
  - lane1: rd = 5, imm = 0xFFFFFFFC, ctrls = 0xF4.
  - dep_raw = 00.
- **Hazard (DECODE_HAZARD_EN):** lane0 0x002081B3, lane1 0x00118213 (ADDI x4,x3,1) -> dep_raw = 10, lane1 imm = 1, ctrls = 0xC6. Without the macro -> dep_raw = 00.
- **Store + LUI + mask:**
  - lane0 0x00208423 (SB x2,8(x1)) -> rd = 0, imm = 8, ctrls = 0x4A.
  - lane1 0x123453B7 (LUI x7,0x12345) -> imm = 0x12345000, ctrls = 0xC4.
  - Repeat with mask 01 -> lane_valid = 01, lane1 all zeros.
- **Back-pressure:** hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs bit-stable. Raise out_ready -> next bundle loads the same edge, no bubble.
- **Flush:** flush = 1 together with in_valid = 1 while out_valid = 1 -> out_valid = 0 next cycle, new bundle never appears, in_ready = 1.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - N-wide registered RV32 decode stage with valid/ready handshake and flush.
// Optional intra-bundle RAW flags are built when DECODE_HAZARD_EN is defined.
module decode_stage #(
  parameter int INSTR_WIDTH       = 32,
  parameter int N_INSTR_PER_CYCLE = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [N_INSTR_PER_CYCLE-1:0]         in_lane_mask,
  input  logic [N_INSTR_PER_CYCLE*INSTR_WIDTH-1:0] instr_in,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N_INSTR_PER_CYCLE-1:0]         lane_valid,
  output logic [N_INSTR_PER_CYCLE*7-1:0]       opcode,
  output logic [N_INSTR_PER_CYCLE*5-1:0]       rd,
  output logic [N_INSTR_PER_CYCLE*3-1:0]       funct3,
  output logic [N_INSTR_PER_CYCLE*5-1:0]       rs1,
  output logic [N_INSTR_PER_CYCLE*5-1:0]       rs2,
  output logic [N_INSTR_PER_CYCLE*7-1:0]       funct7,
  output logic [N_INSTR_PER_CYCLE*32-1:0]      imm,
  output logic [N_INSTR_PER_CYCLE*8-1:0]       ctrls,
  output logic [N_INSTR_PER_CYCLE-1:0]         dep_raw
);

  localparam int N = N_INSTR_PER_CYCLE;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [7:0]  ctrls;
  } dec_t;

  // Fields an instruction does not use are zeroed so the RAW compare never
  // matches on stray encoding bits (e.g. LUI's upper immediate).
  function automatic dec_t decode(input logic [31:0] ins, input logic en);
    dec_t d;
    logic b;
    d = '0;
    b = (ins[14:12] != 3'b000);
    if (en) begin
      case (ins[6:0])
        OP_R: begin
          d.opcode = ins[6:0];
          d.rd     = ins[11:7];
          d.funct3 = ins[14:12];
          d.rs1    = ins[19:15];
          d.rs2    = ins[24:20];
          d.funct7 = ins[31:25];
          d.ctrls  = 8'h82;
        end
        OP_LOAD: begin
          d.opcode = ins[6:0];
          d.rd     = ins[11:7];
          d.funct3 = ins[14:12];
          d.rs1    = ins[19:15];
          d.imm    = {{20{ins[31]}}, ins[31:20]};
          d.ctrls  = {5'b11110, b, 2'b00};
        end
        OP_IMM: begin
          d.opcode = ins[6:0];
          d.rd     = ins[11:7];
          d.funct3 = ins[14:12];
          d.rs1    = ins[19:15];
          d.imm    = {{20{ins[31]}}, ins[31:20]};
          d.ctrls  = 8'hC6;
        end
        OP_STORE: begin
          d.opcode = ins[6:0];
          d.funct3 = ins[14:12];
          d.rs1    = ins[19:15];
          d.rs2    = ins[24:20];
          d.imm    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
          d.ctrls  = {5'b01001, b, 2'b10};
        end
        OP_LUI: begin
          d.opcode = ins[6:0];
          d.rd     = ins[11:7];
          d.funct3 = ins[14:12];
          d.imm    = {ins[31:12], 12'b0};
          d.ctrls  = 8'hC4;
        end
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  dec_t        w_dec [N];
  dec_t        r_dec [N];
  logic        r_out_valid;
  logic [N-1:0] r_lane_valid;
  logic        w_xfer;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dec[i] = decode(instr_in[i*INSTR_WIDTH +: 32], in_lane_mask[i]);
    end
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_lane_valid <= '0;
      for (int i = 0; i < N; i++) r_dec[i] <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_lane_valid <= in_lane_mask;
      for (int i = 0; i < N; i++) r_dec[i] <= w_dec[i];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign lane_valid = r_lane_valid;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign opcode[g*7 +: 7]  = r_dec[g].opcode;
    assign rd[g*5 +: 5]      = r_dec[g].rd;
    assign funct3[g*3 +: 3]  = r_dec[g].funct3;
    assign rs1[g*5 +: 5]     = r_dec[g].rs1;
    assign rs2[g*5 +: 5]     = r_dec[g].rs2;
    assign funct7[g*7 +: 7]  = r_dec[g].funct7;
    assign imm[g*32 +: 32]   = r_dec[g].imm;
    assign ctrls[g*8 +: 8]   = r_dec[g].ctrls;
  end

`ifdef DECODE_HAZARD_EN
  logic [N-1:0] w_dep;
  logic [N-1:0] r_dep;

  // Masked lanes decode to all-zero fields, so rd != 0 and REGWRITE already imply lane validity.
  always_comb begin
    w_dep = '0;
    for (int i = 1; i < N; i++) begin
      for (int j = 0; j < i; j++) begin
        if (in_lane_mask[j] && in_lane_mask[i] && w_dec[j].ctrls[7] &&
            (w_dec[j].rd != 5'd0) &&
            ((w_dec[j].rd == w_dec[i].rs1) || (w_dec[j].rd == w_dec[i].rs2))) begin
          w_dep[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dep <= '0;
    end else if (w_xfer) begin
      r_dep <= w_dep;
    end
  end

  assign dep_raw = r_dep;
`else
  assign dep_raw = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (N = 2).
module tb_decode_stage;

  localparam int N = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_lane_mask;
  logic [N*32-1:0] instr_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  lane_valid;
  logic [N*7-1:0] opcode;
  logic [N*5-1:0] rd;
  logic [N*3-1:0] funct3;
  logic [N*5-1:0] rs1;
  logic [N*5-1:0] rs2;
  logic [N*7-1:0] funct7;
  logic [N*32-1:0] imm;
  logic [N*8-1:0] ctrls;
  logic [N-1:0]  dep_raw;

  int n_checks;
  int n_errors;

  decode_stage #(.INSTR_WIDTH(32), .N_INSTR_PER_CYCLE(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_mask(in_lane_mask), .instr_in(instr_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .lane_valid(lane_valid),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .ctrls(ctrls), .dep_raw(dep_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'hFFC0A283;
  localparam logic [31:0] I_ADDI = 32'h00118213;
  localparam logic [31:0] I_SB   = 32'h00208423;
  localparam logic [31:0] I_LUI  = 32'h123453B7;

  logic [1:0] exp_dep;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_lane_mask = '0;
    instr_in = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_lane_valid", {30'b0, lane_valid}, 32'd0);
    check("rst_ctrls", {16'b0, ctrls}, 32'd0);
    check("rst_imm_lo", imm[31:0], 32'd0);
    check("rst_imm_hi", imm[63:32], 32'd0);
    check("rst_dep", {30'b0, dep_raw}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // R-type + load
    in_valid = 1'b1;
    in_lane_mask = 2'b11;
    instr_in = {I_LW, I_ADD};
    out_ready = 1'b1;
    step();
    check("rl_out_valid", {31'b0, out_valid}, 32'd1);
    check("rl_rd0", {27'b0, rd[4:0]}, 32'd3);
    check("rl_rs1_0", {27'b0, rs1[4:0]}, 32'd1);
    check("rl_rs2_0", {27'b0, rs2[4:0]}, 32'd2);
    check("rl_ctrls0", {24'b0, ctrls[7:0]}, 32'h82);
    check("rl_imm0", imm[31:0], 32'd0);
    check("rl_rd1", {27'b0, rd[9:5]}, 32'd5);
    check("rl_imm1", imm[63:32], 32'hFFFFFFFC);
    check("rl_ctrls1", {24'b0, ctrls[15:8]}, 32'hF4);
    check("rl_funct3_1", {29'b0, funct3[5:3]}, 32'd2);
    check("rl_dep", {30'b0, dep_raw}, 32'd0);

    // Hazard bundle, back-to-back with the previous one
    instr_in = {I_ADDI, I_ADD};
    step();
`ifdef DECODE_HAZARD_EN
    exp_dep = 2'b10;
`else
    exp_dep = 2'b00;
`endif
    check("hz_out_valid", {31'b0, out_valid}, 32'd1);
    check("hz_dep", {30'b0, dep_raw}, {30'b0, exp_dep});
    check("hz_imm1", imm[63:32], 32'd1);
    check("hz_ctrls1", {24'b0, ctrls[15:8]}, 32'hC6);
    check("hz_rs1_1", {27'b0, rs1[9:5]}, 32'd3);
    check("hz_rd1", {27'b0, rd[9:5]}, 32'd4);

    // Store + LUI
    instr_in = {I_LUI, I_SB};
    step();
    check("sl_rd0", {27'b0, rd[4:0]}, 32'd0);
    check("sl_imm0", imm[31:0], 32'd8);
    check("sl_ctrls0", {24'b0, ctrls[7:0]}, 32'h4A);
    check("sl_imm1", imm[63:32], 32'h12345000);
    check("sl_ctrls1", {24'b0, ctrls[15:8]}, 32'hC4);
    check("sl_rd1", {27'b0, rd[9:5]}, 32'd7);
    check("sl_rs1_1", {27'b0, rs1[9:5]}, 32'd0);
    check("sl_dep", {30'b0, dep_raw}, 32'd0);

    // Same bundle with lane 1 masked
    in_lane_mask = 2'b01;
    step();
    check("mk_lane_valid", {30'b0, lane_valid}, 32'd1);
    check("mk_imm0", imm[31:0], 32'd8);
    check("mk_opcode1", {25'b0, opcode[13:7]}, 32'd0);
    check("mk_rd1", {27'b0, rd[9:5]}, 32'd0);
    check("mk_imm1", imm[63:32], 32'd0);
    check("mk_ctrls1", {24'b0, ctrls[15:8]}, 32'd0);

    // Back-pressure: hold out_ready low for 3 cycles
    out_ready = 1'b0;
    in_lane_mask = 2'b11;
    instr_in = {I_LW, I_ADD};
    #1;
    check("bp_in_ready0", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_lane_valid", {30'b0, lane_valid}, 32'd1);
      check("bp_imm0", imm[31:0], 32'd8);
      check("bp_ctrls", {16'b0, ctrls}, 32'h004A);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_nb_out_valid", {31'b0, out_valid}, 32'd1);
    check("bp_nb_ctrls0", {24'b0, ctrls[7:0]}, 32'h82);
    check("bp_nb_imm1", imm[63:32], 32'hFFFFFFFC);
    check("bp_nb_lane_valid", {30'b0, lane_valid}, 32'd3);

    // Flush while holding a bundle and presenting a new one
    out_ready = 1'b0;
    flush = 1'b1;
    instr_in = {I_ADDI, I_ADD};
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_out_valid", {31'b0, out_valid}, 32'd0);
    check("fl_in_ready", {31'b0, in_ready}, 32'd1);
    check("fl_ctrls1_held", {24'b0, ctrls[15:8]}, 32'hF4);
    step();
    check("fl_out_valid2", {31'b0, out_valid}, 32'd0);
    check("fl_imm1_held", imm[63:32], 32'hFFFFFFFC);

    // Drain: out_valid clears, fields hold
    in_valid = 1'b1;
    out_ready = 1'b1;
    instr_in = {I_LUI, I_SB};
    step();
    in_valid = 1'b0;
    check("dr_out_valid1", {31'b0, out_valid}, 32'd1);
    step();
    check("dr_out_valid0", {31'b0, out_valid}, 32'd0);
    check("dr_imm1_held", imm[63:32], 32'h12345000);

    // Reset mid-stream
    in_valid = 1'b1;
    instr_in = {I_LW, I_ADD};
    step();
    check("rm_out_valid_pre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rm_out_valid", {31'b0, out_valid}, 32'd0);
    check("rm_ctrls", {16'b0, ctrls}, 32'd0);
    check("rm_imm_hi", imm[63:32], 32'd0);
    check("rm_lane_valid", {30'b0, lane_valid}, 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rm_in_ready", {31'b0, in_ready}, 32'd1);
    check("rm_rd", {22'b0, rd}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
